// File: rtl/mcu_pkg.sv
// Shared MCU constants: ALU opcodes, ARM-style condition codes and NZCV flag bit positions.
// Used by the ALU, the decoder, the branch unit and the writeback stage.
package mcu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_ORR = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_MOV = 3'b100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Only ADD and SUB produce meaningful carry/overflow; logical ops leave C and V alone.
    function automatic logic op_writes_cv(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM-style condition evaluator over NZCV flags.
// Shared between the writeback stage and the branch unit.
module cond_eval
    import mcu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback.sv
// Execute-to-writeback stage: owns the NZCV register, applies condition codes and
// holds a one-entry writeback request for the register file; annulled instructions are counted.
module alu_writeback
    import mcu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      alu_result,
    input  logic [3:0]       alu_flags,
    input  logic [2:0]       alu_op,
    input  logic [3:0]       in_rd,
    input  logic             in_reg_write,
    input  logic             in_set_flags,
    input  logic [3:0]       in_cond,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [3:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic             wb_we,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] annul_cnt
);

    logic pass;
    logic legal;
    logic acc;
    logic exec;
    logic annul;

    cond_eval u_cond_eval (
        .cond  (in_cond),
        .flags (flags_q),
        .pass  (pass)
    );

    // Gated by rst_n so nothing is accepted while the stage is held in reset.
    assign in_ready = rst_n & (~wb_valid | wb_ready);
    assign acc      = in_valid & in_ready;
    assign legal    = (alu_op <= ALU_MOV);
    assign exec     = acc & pass & legal;
    assign annul    = acc & ~exec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q   <= '0;
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            annul_cnt <= '0;
        end else begin
            if (exec && in_set_flags) begin
                flags_q[FLAG_N] <= alu_flags[FLAG_N];
                flags_q[FLAG_Z] <= alu_flags[FLAG_Z];
                if (op_writes_cv(alu_op)) begin
                    flags_q[FLAG_C] <= alu_flags[FLAG_C];
                    flags_q[FLAG_V] <= alu_flags[FLAG_V];
                end
            end

            // A new entry wins over a drain in the same cycle, giving full throughput.
            if (exec && in_reg_write) begin
                wb_valid <= 1'b1;
                wb_we    <= 1'b1;
                wb_rd    <= in_rd;
                wb_data  <= alu_result;
            end else if (wb_valid && wb_ready) begin
                wb_valid <= 1'b0;
            end

            if (annul && (annul_cnt != {CNT_W{1'b1}})) begin
                annul_cnt <= annul_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback: flags, conditions, backpressure,
// annul counting with saturation, and reset of a pending entry.
module tb_alu_writeback;
    import mcu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic [2:0]  alu_op;
    logic [3:0]  in_rd;
    logic        in_reg_write;
    logic        in_set_flags;
    logic [3:0]  in_cond;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_we;
    logic [3:0]  flags_q;
    logic [15:0] annul_cnt;

    int checks = 0;
    int errors = 0;
    int exp_annul = 0;

    alu_writeback #(.CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_result   (alu_result),
        .alu_flags    (alu_flags),
        .alu_op       (alu_op),
        .in_rd        (in_rd),
        .in_reg_write (in_reg_write),
        .in_set_flags (in_set_flags),
        .in_cond      (in_cond),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_we        (wb_we),
        .flags_q      (flags_q),
        .annul_cnt    (annul_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] res,
                                  input logic [3:0] fl, input logic [3:0] cond,
                                  input logic [3:0] rd, input logic we, input logic sf);
        in_valid     = 1'b1;
        alu_op       = op;
        alu_result   = res;
        alu_flags    = fl;
        in_cond      = cond;
        in_rd        = rd;
        in_reg_write = we;
        in_set_flags = sf;
    endtask

    task automatic go_idle();
        in_valid     = 1'b0;
        in_reg_write = 1'b0;
        in_set_flags = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        go_idle();
        wb_ready = 1'b1;
        alu_op = ALU_AND; alu_result = '0; alu_flags = '0; in_cond = COND_AL; in_rd = '0;
        step();
        step();
        checks++;
        if ({wb_valid, wb_we, wb_rd, wb_data, flags_q, annul_cnt} !== 58'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got v=%0b we=%0b rd=%0d data=%h flags=%b cnt=%0d, expected all zero",
                     wb_valid, wb_we, wb_rd, wb_data, flags_q, annul_cnt);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %0b expected 0", in_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_in_ready: got %0b expected 1", in_ready);
        end
    endtask

    task automatic test_add();
        apply_stimulus(ALU_ADD, 32'd0, 4'b0110, COND_AL, 4'd3, 1'b1, 1'b1);
        step();
        go_idle();
        checks++;
        if ({wb_valid, wb_we, wb_rd, wb_data} !== {1'b1, 1'b1, 4'd3, 32'd0}) begin
            errors++;
            $display("[TB] FAIL add_entry: got v=%0b we=%0b rd=%0d data=%h expected v=1 we=1 rd=3 data=0",
                     wb_valid, wb_we, wb_rd, wb_data);
        end
        checks++;
        if (flags_q !== 4'b0110) begin
            errors++;
            $display("[TB] FAIL add_flags: got %b expected 0110", flags_q);
        end
        step();
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_drain: got wb_valid=%0b expected 0", wb_valid);
        end
    endtask

    task automatic test_logic_flags();
        // Flag-only SUB (CMP style): flags update, no writeback entry.
        apply_stimulus(ALU_SUB, 32'h1234, 4'b0011, COND_AL, 4'd9, 1'b0, 1'b1);
        step();
        go_idle();
        checks++;
        if ({wb_valid, flags_q} !== {1'b0, 4'b0011}) begin
            errors++;
            $display("[TB] FAIL cmp_no_entry: got v=%0b flags=%b expected v=0 flags=0011", wb_valid, flags_q);
        end
        apply_stimulus(ALU_ORR, 32'h8000_0000, 4'b1000, COND_AL, 4'd1, 1'b0, 1'b1);
        step();
        go_idle();
        checks++;
        if (flags_q !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL orr_cv_preserved: got %b expected 1011", flags_q);
        end
    endtask

    task automatic test_cond();
        apply_stimulus(ALU_SUB, 32'd0, 4'b0100, COND_AL, 4'd0, 1'b0, 1'b1);
        step();
        checks++;
        if (flags_q !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL cond_setup_flags: got %b expected 0100", flags_q);
        end
        apply_stimulus(ALU_ADD, 32'h11, 4'b1011, COND_NE, 4'd5, 1'b1, 1'b1);
        step();
        exp_annul++;
        checks++;
        if ({wb_valid, flags_q, annul_cnt} !== {1'b0, 4'b0100, 16'(exp_annul)}) begin
            errors++;
            $display("[TB] FAIL ne_annul: got v=%0b flags=%b cnt=%0d expected v=0 flags=0100 cnt=%0d",
                     wb_valid, flags_q, annul_cnt, exp_annul);
        end
        // HI needs C&!Z: fails with Z set.
        apply_stimulus(ALU_MOV, 32'h22, 4'b0000, COND_HI, 4'd6, 1'b1, 1'b0);
        step();
        exp_annul++;
        checks++;
        if ({wb_valid, annul_cnt} !== {1'b0, 16'(exp_annul)}) begin
            errors++;
            $display("[TB] FAIL hi_annul: got v=%0b cnt=%0d expected v=0 cnt=%0d", wb_valid, annul_cnt, exp_annul);
        end
        apply_stimulus(ALU_MOV, 32'h33, 4'b0000, COND_LE, 4'd6, 1'b1, 1'b0);
        step();
        checks++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 4'd6, 32'h33}) begin
            errors++;
            $display("[TB] FAIL le_pass: got v=%0b rd=%0d data=%h expected v=1 rd=6 data=33", wb_valid, wb_rd, wb_data);
        end
        apply_stimulus(ALU_AND, 32'h55, 4'b0000, COND_EQ, 4'd5, 1'b1, 1'b0);
        step();
        go_idle();
        checks++;
        if ({wb_valid, wb_rd, wb_data, annul_cnt} !== {1'b1, 4'd5, 32'h55, 16'(exp_annul)}) begin
            errors++;
            $display("[TB] FAIL eq_pass: got v=%0b rd=%0d data=%h cnt=%0d expected v=1 rd=5 data=55 cnt=%0d",
                     wb_valid, wb_rd, wb_data, annul_cnt, exp_annul);
        end
    endtask

    task automatic test_backpressure();
        wb_ready = 1'b0;
        apply_stimulus(ALU_ADD, 32'hAAAA, 4'b0000, COND_AL, 4'd7, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({in_ready, wb_valid, wb_rd, wb_data} !== {1'b0, 1'b1, 4'd5, 32'h55}) begin
                errors++;
                $display("[TB] FAIL stall_hold cycle %0d: got rdy=%0b v=%0b rd=%0d data=%h expected rdy=0 v=1 rd=5 data=55",
                         i, in_ready, wb_valid, wb_rd, wb_data);
            end
            step();
        end
        wb_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_release_ready: got %0b expected 1", in_ready);
        end
        step();
        go_idle();
        checks++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 4'd7, 32'hAAAA}) begin
            errors++;
            $display("[TB] FAIL drain_and_load: got v=%0b rd=%0d data=%h expected v=1 rd=7 data=aaaa",
                     wb_valid, wb_rd, wb_data);
        end
        step();
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL final_drain: got %0b expected 0", wb_valid);
        end
    endtask

    task automatic test_back_to_back();
        // k sets Z, k+1 (EQ) must see it, k+2 (NE) must annul.
        apply_stimulus(ALU_SUB, 32'd0, 4'b0110, COND_AL, 4'd2, 1'b1, 1'b1);
        step();
        apply_stimulus(ALU_ADD, 32'h77, 4'b0000, COND_EQ, 4'd8, 1'b1, 1'b0);
        step();
        checks++;
        if ({wb_valid, wb_rd, wb_data, flags_q} !== {1'b1, 4'd8, 32'h77, 4'b0110}) begin
            errors++;
            $display("[TB] FAIL b2b_eq: got v=%0b rd=%0d data=%h flags=%b expected v=1 rd=8 data=77 flags=0110",
                     wb_valid, wb_rd, wb_data, flags_q);
        end
        apply_stimulus(ALU_ADD, 32'h88, 4'b0000, COND_NE, 4'd9, 1'b1, 1'b0);
        step();
        go_idle();
        exp_annul++;
        checks++;
        if ({wb_valid, annul_cnt} !== {1'b0, 16'(exp_annul)}) begin
            errors++;
            $display("[TB] FAIL b2b_ne: got v=%0b cnt=%0d expected v=0 cnt=%0d", wb_valid, annul_cnt, exp_annul);
        end
    endtask

    task automatic test_illegal_and_saturation();
        apply_stimulus(3'b101, 32'hDEAD, 4'b1001, COND_AL, 4'd4, 1'b1, 1'b1);
        step();
        go_idle();
        exp_annul++;
        checks++;
        if ({wb_valid, flags_q, annul_cnt} !== {1'b0, 4'b0110, 16'(exp_annul)}) begin
            errors++;
            $display("[TB] FAIL illegal_op: got v=%0b flags=%b cnt=%0d expected v=0 flags=0110 cnt=%0d",
                     wb_valid, flags_q, annul_cnt, exp_annul);
        end
        apply_stimulus(ALU_ADD, 32'd1, 4'b0000, COND_NV, 4'd1, 1'b1, 1'b1);
        for (int i = 0; i < 32'h0000_FFFF + 2; i++) begin
            @(posedge clk);
        end
        #1;
        go_idle();
        checks++;
        if ({wb_valid, annul_cnt} !== {1'b0, 16'hFFFF}) begin
            errors++;
            $display("[TB] FAIL annul_saturate: got v=%0b cnt=%h expected v=0 cnt=ffff", wb_valid, annul_cnt);
        end
    endtask

    task automatic test_reset_pending();
        wb_ready = 1'b0;
        apply_stimulus(ALU_ADD, 32'hFFFF_0000, 4'b1111, COND_AL, 4'd15, 1'b1, 1'b1);
        step();
        checks++;
        if ({wb_valid, flags_q} !== {1'b1, 4'b1111}) begin
            errors++;
            $display("[TB] FAIL pre_reset_state: got v=%0b flags=%b expected v=1 flags=1111", wb_valid, flags_q);
        end
        rst_n = 1'b0;
        wb_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_blocks_accept: got in_ready=%0b expected 0", in_ready);
        end
        step();
        checks++;
        if ({wb_valid, wb_we, wb_rd, wb_data, flags_q, annul_cnt} !== 58'd0) begin
            errors++;
            $display("[TB] FAIL reset_pending: got v=%0b we=%0b rd=%0d data=%h flags=%b cnt=%h expected all zero",
                     wb_valid, wb_we, wb_rd, wb_data, flags_q, annul_cnt);
        end
        go_idle();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_logic_flags();
        test_cond();
        test_backpressure();
        test_back_to_back();
        test_illegal_and_saturation();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Execute-to-writeback stage directly downstream of the ALU. Accepts the ALU's 32-bit result and NZCV flags with instruction sideband via a valid/ready handshake. Owns the architectural NZCV flag register and evaluates the instruction's ARM-style condition code against it. Presents a registered, one-entry writeback request to the register file; annulled instructions are dropped and counted.

## Interface
Parameters:
- `CNT_W`, default 16: width of the annul counter.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `in_valid`, input, 1: ALU output and sideband are valid.
- `in_ready`, output, 1: stage can accept this cycle.
- `alu_result`, input, 32: ALU result.
- `alu_flags`, input, 4: ALU flags, ordered {N,Z,C,V}.
- `alu_op`, input, 3: ALUOp that produced the result (000 AND, 001 ORR, 010 ADD, 011 SUB, 100 MOV).
- `in_rd`, input, 4: destination register index.
- `in_reg_write`, input, 1: instruction writes `in_rd`.
- `in_set_flags`, input, 1: instruction updates NZCV (S bit).
- `in_cond`, input, 4: condition code.
- `wb_valid`, output, 1: writeback entry pending.
- `wb_ready`, input, 1: register file consumes the entry.
- `wb_rd`, output, 4: destination index.
- `wb_data`, output, 32: data to write.
- `wb_we`, output, 1: write enable, qualified by `wb_valid`.
- `flags_q`, output, 4: architectural NZCV {N,Z,C,V}, for the branch/control logic.
- `annul_cnt`, output, CNT_W: number of annulled instructions, saturating.

## Operation
- Accept: `acc = in_valid & in_ready`. `in_ready = ~wb_valid | wb_ready`; it is combinational from `wb_ready`.
- Condition `pass` is evaluated on `in_cond` against the current `flags_q`:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 never.
- `legal` = `alu_op` ≤ 100. `exec = acc & pass & legal`.
- Annul (`acc & ~exec`):
  - No flag update and no writeback entry.
  - `annul_cnt` increments, saturating at all-ones.
- Flag update, when `exec & in_set_flags`:
  - N and Z are always taken from `alu_flags`.
  - C and V are taken from `alu_flags` only for ADD/SUB.
  - For AND/ORR/MOV, C and V keep the old `flags_q` values. The ALU drives C=V=0 for these ops, and that must not reach the flag register.
- Writeback, when `exec & in_reg_write`: load `wb_rd`, `wb_data`, set `wb_we=1`, `wb_valid=1`.
- `exec` with `in_reg_write=0`, for example CMP-style flag-only operations, creates no entry.
- Entry clearing: `wb_valid` clears on `wb_valid & wb_ready` unless a new entry loads in the same cycle.
- Simultaneous drain and load in one cycle: the new entry replaces the old one, giving full throughput with no bubble.
- While `wb_valid & ~wb_ready`, the entry's `wb_rd`, `wb_data` and `wb_we` hold stable and `in_ready=0`.

## Timing
- Latency is one cycle: an instruction accepted at edge k makes `wb_valid` high after edge k, and `flags_q` updates at the same edge.
- Back-to-back instructions: instruction k+1 evaluates its condition against flags already updated by k. No forwarding path is needed.
- Reset (`rst_n=0` at an edge) sets: `flags_q=0000`, `wb_valid=0`, `wb_we=0`, `wb_rd=0`, `wb_data=0`, `annul_cnt=0`.
- A pending entry is discarded on reset.
- `in_ready` evaluates low during reset, so nothing is accepted.
- No output changes except on a clock edge. `in_ready` is the only combinational output.

## Structure
- Shared package `mcu_pkg` holds:
  - ALUOp constants (`ALU_AND` … `ALU_MOV`).
  - Condition-code constants (`COND_EQ` … `COND_NV`).
  - Flag bit indices (`FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`).
- These constants are shared with the ALU and the decoder.
- One combinational sub-module `cond_eval` has inputs `cond[3:0]`, `flags[3:0]` and output `pass`. It is reused by the branch unit.
- Flag register, writeback register and counter live in `alu_writeback` itself.

## Test plan
- Reset, then `alu_op=ADD`, `alu_result=0`, `alu_flags=0110`, `set_flags=1`, `cond=AL`, `rd=3`, `reg_write=1`:
  - Next cycle `wb_valid=1`, `wb_rd=3`, `wb_data=0`, `flags_q=0110`.
- With `flags_q=0011`, issue ORR with `alu_flags=1000` and `set_flags=1` → `flags_q=1011` (C and V preserved).
- With `flags_q=0100` (Z=1):
  - Issue NE with `rd=5` → no entry, `annul_cnt=1`, flags unchanged.
  - Issue EQ → entry to `rd=5`.
- Hold `wb_ready=0` for 3 cycles with `in_valid=1`:
  - `in_ready=0` and the `wb_data` value is stable throughout.
  - Raise `wb_ready` → the next instruction loads in the same cycle the old entry drains.
- Issue `alu_op=101` with `cond=AL` → annulled, counter increments, no flag change. Drive 0xFFFF+2 annuls → `annul_cnt=0xFFFF`.
- Assert `rst_n=0` with `wb_valid=1` and `flags_q=1111` → after the edge, all outputs are zero.
